// File: rtl/spi_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_pkg
// Brief  : Frame layout, register map and helpers for the SPI register bank.
// Rev    : 1.0
// ============================================================================
package spi_reg_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int ADDR_BITS    = 7;
    localparam int DATA_BITS    = 8;
    localparam int RW_BIT       = 15;
    localparam int NUM_REGS     = 9;
    localparam int REG_IDX_BITS = $clog2(NUM_REGS);
    localparam int CNT_BITS     = 5;

    localparam int ADDR_EN_OUT       = 'h00;
    localparam int ADDR_EN_PWM_OUT   = 'h01;
    localparam int ADDR_CH_3_0       = 'h02;
    localparam int ADDR_CH_7_4       = 'h03;
    localparam int ADDR_G0_CH0_DUTY  = 'h04;
    localparam int ADDR_G0_CH1_DUTY  = 'h05;
    localparam int ADDR_G1_CH0_DUTY  = 'h06;
    localparam int ADDR_G1_CH1_DUTY  = 'h07;
    localparam int ADDR_FREQ_DIV     = 'h08;

    // Bit-count milestones: command byte complete, first tx shift, full frame
    localparam logic [CNT_BITS-1:0] CNT_CMD_LAST = CNT_BITS'(FRAME_BITS - DATA_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_TX_SHIFT = CNT_BITS'(FRAME_BITS - DATA_BITS + 1);
    localparam logic [CNT_BITS-1:0] CNT_FULL     = CNT_BITS'(FRAME_BITS);

    typedef struct packed {
        logic                 rw;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } frame_t;

    function automatic logic addr_implemented(input logic [ADDR_BITS-1:0] addr,
                                              input int                   max_addr);
        return (int'(addr) <= max_addr) && (int'(addr) < NUM_REGS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_bank_if
// Brief  : SPI pin bundle between an external controller and the target.
// Rev    : 1.0
// ============================================================================
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;
    logic cipo_oe;

    modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
    modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface
`default_nettype wire

// File: rtl/spi_reg_bank_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop synchronizer plus one edge register giving rise/fall pulses.
// Rev    : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        edge_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            edge_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = o_level & ~edge_q;
    assign o_fall  = ~o_level & edge_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : spi_reg_bank
// Brief  : SPI mode-0 target holding the nine PWM configuration registers.
// Rev    : 1.0
// ============================================================================
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_bank_if.slave        spi,
    output logic [DATA_BITS-1:0] reg_en_out,
    output logic [DATA_BITS-1:0] reg_en_pwm_out,
    output logic [DATA_BITS-1:0] reg_out_3_0_pwm_gen_channel,
    output logic [DATA_BITS-1:0] reg_out_7_4_pwm_gen_channel,
    output logic [DATA_BITS-1:0] reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [DATA_BITS-1:0] reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [DATA_BITS-1:0] reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [DATA_BITS-1:0] reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [DATA_BITS-1:0] reg_pwm_gen_1_0_frequency_divider
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi_level, w_copi_rise_unused, w_copi_fall_unused;
    logic w_ncs_level, w_ncs_rise, w_ncs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(spi.sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .i_async(spi.copi),
        .o_level(w_copi_level), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .i_async(spi.ncs),
        .o_level(w_ncs_level), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  err_q, err_d;
    logic [DATA_BITS-1:0]  tx_q, tx_d;
    logic                  oe_q, oe_d;
    logic [DATA_BITS-1:0]  regs_q [NUM_REGS];
    logic [DATA_BITS-1:0]  regs_d [NUM_REGS];

    frame_t                w_frame;
    logic [FRAME_BITS-1:0] w_shift_in;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [DATA_BITS-1:0]  w_rd_data;
    logic                  w_commit;

    assign w_frame    = frame_t'(shift_q);
    assign w_shift_in = {shift_q[FRAME_BITS-2:0], w_copi_level};
    assign w_rd_addr  = w_shift_in[ADDR_BITS-1:0];
    assign w_rd_data  = addr_implemented(w_rd_addr, MAX_ADDR)
                      ? regs_q[w_rd_addr[REG_IDX_BITS-1:0]] : '0;
    assign w_commit   = w_frame.rw && (bit_cnt_q == CNT_FULL) && !err_q
                      && addr_implemented(w_frame.addr, MAX_ADDR);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        err_d     = err_q;
        tx_d      = tx_q;
        oe_d      = oe_q;
        regs_d    = regs_q;
        if (w_ncs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            err_d     = 1'b0;
            tx_d      = '0;
            oe_d      = 1'b0;
        end else if (w_ncs_level) begin
            // Deselected: drop the pad and clear tx so cipo reads 0 while idle
            tx_d = '0;
            oe_d = 1'b0;
            if (w_ncs_rise && w_commit) begin
                regs_d[w_frame.addr[REG_IDX_BITS-1:0]] = w_frame.data;
            end
        end else if (w_sclk_rise) begin
            shift_d = w_shift_in;
            if (bit_cnt_q == CNT_FULL) begin
                err_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            if (bit_cnt_q == CNT_CMD_LAST && !w_shift_in[RW_BIT-DATA_BITS]) begin
                tx_d = w_rd_data;
                oe_d = 1'b1;
            end
        end else if (w_sclk_fall && bit_cnt_q >= CNT_TX_SHIFT) begin
            // The falling edge right after the command byte keeps bit7 in place
            tx_d = {tx_q[DATA_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            tx_q      <= '0;
            oe_q      <= 1'b0;
            regs_q    <= '{default: '0};
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
            oe_q      <= oe_d;
            regs_q    <= regs_d;
        end
    end

    assign spi.cipo    = tx_q[DATA_BITS-1];
    assign spi.cipo_oe = oe_q;

    assign reg_en_out                        = regs_q[ADDR_EN_OUT];
    assign reg_en_pwm_out                    = regs_q[ADDR_EN_PWM_OUT];
    assign reg_out_3_0_pwm_gen_channel       = regs_q[ADDR_CH_3_0];
    assign reg_out_7_4_pwm_gen_channel       = regs_q[ADDR_CH_7_4];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[ADDR_G0_CH0_DUTY];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[ADDR_G0_CH1_DUTY];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[ADDR_G1_CH0_DUTY];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[ADDR_G1_CH1_DUTY];
    assign reg_pwm_gen_1_0_frequency_divider = regs_q[ADDR_FREQ_DIV];

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_reg_bank
// Brief  : Scoreboard bench for spi_reg_bank: frame-level model, read and register monitors.
// Rev    : 1.0
// ============================================================================
module tb_spi_reg_bank;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 8;
    localparam int HALF_SCLK   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_bank_if spi();
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    spi_reg_bank #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .reg_en_out(r0), .reg_en_pwm_out(r1),
        .reg_out_3_0_pwm_gen_channel(r2), .reg_out_7_4_pwm_gen_channel(r3),
        .reg_pwm_gen_0_ch_0_duty_cycle(r4), .reg_pwm_gen_0_ch_1_duty_cycle(r5),
        .reg_pwm_gen_1_ch_0_duty_cycle(r6), .reg_pwm_gen_1_ch_1_duty_cycle(r7),
        .reg_pwm_gen_1_0_frequency_divider(r8)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_regs [0:8];
    logic [71:0] reg_exp_q [$];
    logic [7:0]  rd_exp_q  [$];
    logic [71:0] mon_prev = '0;
    logic [71:0] mon_exp;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model_snap();
        logic [71:0] s;
        for (int i = 0; i < 9; i++) s[8*i +: 8] = model_regs[i];
        return s;
    endfunction

    function automatic logic [71:0] dut_snap();
        return {r8, r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    // Frame-level reference: a complete 16-bit write to an implemented address
    // commits; a full read returns the stored byte or zero.
    task automatic model_frame(input logic [15:0] f, input int nbits);
        int addr;
        addr = int'(f[14:8]);
        if (nbits == 16 && f[15] && addr <= MAX_ADDR) model_regs[addr] = f[7:0];
        if (nbits >= 16 && !f[15]) rd_exp_q.push_back(addr <= MAX_ADDR ? model_regs[addr] : 8'h00);
        reg_exp_q.push_back(model_snap());
    endtask

    task automatic send_frame(input logic [15:0] f, input int nbits, input bit raise_ncs);
        int idx;
        if (raise_ncs) model_frame(f, nbits);
        @(negedge clk);
        spi.ncs = 1'b0;
        repeat (2 * HALF_SCLK) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            idx = 15 - i;
            spi.copi = (i < 16) ? f[idx] : 1'($urandom);
            repeat (HALF_SCLK) @(negedge clk);
            spi.sclk = 1'b1;
            repeat (HALF_SCLK) @(negedge clk);
            spi.sclk = 1'b0;
        end
        if (raise_ncs) begin
            repeat (HALF_SCLK) @(negedge clk);
            spi.ncs = 1'b1;
            repeat (4 * HALF_SCLK) @(negedge clk);
        end
    endtask

    // Read monitor: a frame whose cipo_oe is up at the 9th rising edge is a
    // read; its data byte is captured on rises 9..16 and scored.
    int         rise_idx  = 0;
    bit         rd_active = 1'b0;
    bit         rd_oe_ok  = 1'b0;
    logic [7:0] rd_bits   = '0;

    always @(negedge spi.ncs) begin
        rise_idx  = 0;
        rd_active = 1'b0;
    end

    always @(posedge spi.sclk) begin
        if (rst_n && !spi.ncs) begin
            rise_idx++;
            if (rise_idx == 8) check("cipo_oe_during_cmd", 72'(spi.cipo_oe), 72'd0);
            if (rise_idx == 9) begin
                rd_active = spi.cipo_oe;
                rd_oe_ok  = 1'b1;
                rd_bits   = '0;
            end
            if (rd_active && rise_idx >= 9 && rise_idx <= 16) begin
                rd_bits  = {rd_bits[6:0], spi.cipo};
                rd_oe_ok = rd_oe_ok & spi.cipo_oe;
            end
            if (rd_active && rise_idx == 16) begin
                check("cipo_oe_during_data", 72'(rd_oe_ok), 72'd1);
                if (rd_exp_q.size() == 0) begin
                    check("read_unexpected", 72'(rd_bits), 72'hxx);
                end else begin
                    check("read_data", 72'(rd_bits), 72'(rd_exp_q.pop_front()));
                end
            end
        end
    end

    // Register monitor: the commit lands on the third clk edge counting the
    // edge that first samples ncs high; the edge before must still show old values.
    initial begin
        forever begin
            @(posedge spi.ncs);
            if (rst_n) begin
                repeat (SYNC_STAGES) @(posedge clk);
                #1;
                check("regs_before_commit", dut_snap(), mon_prev);
                @(posedge clk);
                #1;
                if (reg_exp_q.size() == 0) begin
                    check("regs_unexpected_frame", dut_snap(), 72'hx);
                end else begin
                    mon_exp = reg_exp_q.pop_front();
                    check("regs_after_commit", dut_snap(), mon_exp);
                    mon_prev = mon_exp;
                end
                check("cipo_idle_after_frame", 72'({spi.cipo_oe, spi.cipo}), 72'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f;
        int          nb;
        int          sel;
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        for (int i = 0; i < 9; i++) model_regs[i] = 8'h00;

        repeat (5) @(negedge clk);
        check("reset_regs", dut_snap(), 72'd0);
        check("reset_cipo", 72'({spi.cipo_oe, spi.cipo}), 72'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(16'h8455, 16, 1'b1);

        for (int a = 0; a < 9; a++) send_frame({1'b1, 7'(a), 8'((a + 1) * 'h11)}, 16, 1'b1);
        for (int a = 0; a < 9; a++) send_frame({1'b0, 7'(a), 8'h00}, 16, 1'b1);

        send_frame(16'h8A3C, 16, 1'b1);
        send_frame(16'h0A00, 16, 1'b1);

        send_frame(16'h80AB, 12, 1'b1);
        send_frame(16'h80F0, 16, 1'b1);
        check("abort_then_full_write", 72'(r0), 72'hF0);

        send_frame(16'h81CC, 17, 1'b1);
        send_frame(16'h81AA, 16, 1'b1);
        check("overrun_then_full_write", 72'(r1), 72'hAA);

        for (int n = 0; n < 24; n++) begin
            f[15]   = 1'($urandom_range(0, 1));
            f[14:8] = 7'($urandom_range(0, 11));
            f[7:0]  = 8'($urandom);
            sel     = $urandom_range(0, 4);
            nb      = (!f[15] || sel >= 2) ? 16 : (sel == 0 ? 12 : 17);
            send_frame(f, nb, 1'b1);
        end

        send_frame(16'h8877, 16, 1'b1);
        send_frame(16'h8877, 10, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_regs", dut_snap(), 72'd0);
        check("midframe_reset_cipo", 72'({spi.cipo_oe, spi.cipo}), 72'd0);
        repeat (3) @(negedge clk);
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 9; i++) model_regs[i] = 8'h00;
        mon_prev = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h0800, 16, 1'b1);
        send_frame(16'h88C3, 16, 1'b1);
        check("write_after_reset", 72'(r8), 72'hC3);

        repeat (20) @(negedge clk);
        check("read_queue_drained", 72'(rd_exp_q.size()), 72'd0);
        check("reg_queue_drained", 72'(reg_exp_q.size()), 72'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
